// File: rtl/seg_blink_scan_if.sv
`default_nettype none
// ============================================================================
// Module   : seg_blink_scan_if
// Brief    : Operand/cursor inputs and 7-segment pin outputs of seg_blink_scan.
// Revision : 1.0 - initial release
// ============================================================================
interface seg_blink_scan_if;
    logic [31:0] a_val;
    logic [31:0] b_val;
    logic        sel;
    logic [7:0]  blink;
    logic        blink_en;
    logic [7:0]  dp_mask;
    logic [7:0]  an;
    logic [6:0]  seg;
    logic        dp;

    // master: operand-entry side driving the display; slave: the display driver
    modport master (
        output a_val, b_val, sel, blink, blink_en, dp_mask,
        input  an, seg, dp
    );
    modport slave (
        input  a_val, b_val, sel, blink, blink_en, dp_mask,
        output an, seg, dp
    );
endinterface
`default_nettype wire

// File: rtl/seg_blink_scan.sv
`default_nettype none
// ============================================================================
// Module   : seg_blink_scan
// Brief    : 8-digit common-anode 7-segment scanner with hex decode and
//            blinking of the cursor digit(s).
// Revision : 1.0 - initial release
// ============================================================================
module seg_blink_scan #(
    parameter int SCAN_DIV  = 100000,
    parameter int BLINK_DIV = 25000000
) (
    input  logic              clk,
    input  logic              rst,
    seg_blink_scan_if.slave   bus
);

    // A divide-by-1 still needs a one-bit counter that simply stays at zero
    localparam int SCAN_W  = (SCAN_DIV  > 1) ? $clog2(SCAN_DIV)  : 1;
    localparam int BLINK_W = (BLINK_DIV > 1) ? $clog2(BLINK_DIV) : 1;

    localparam logic [SCAN_W-1:0]  SCAN_LAST  = SCAN_W'(SCAN_DIV - 1);
    localparam logic [BLINK_W-1:0] BLINK_LAST = BLINK_W'(BLINK_DIV - 1);
    localparam logic [SCAN_W-1:0]  SCAN_ONE   = SCAN_W'(1);
    localparam logic [BLINK_W-1:0] BLINK_ONE  = BLINK_W'(1);

    localparam logic [7:0] AN_OFF  = 8'hFF;
    localparam logic [6:0] SEG_OFF = 7'h7F;

    logic [SCAN_W-1:0]  scan_cnt_q,  scan_cnt_d;
    logic [2:0]         idx_q,       idx_d;
    logic [BLINK_W-1:0] blink_cnt_q, blink_cnt_d;
    logic               phase_q,     phase_d;
    logic [7:0]         an_q,        an_d;
    logic [6:0]         seg_q,       seg_d;
    logic               dp_q,        dp_d;

    logic [3:0]         nib;
    logic               blank;

    // Active-low segment pattern, bit order {g,f,e,d,c,b,a}
    function automatic logic [6:0] hex7(input logic [3:0] v);
        logic [6:0] s;
        case (v)
            4'h0:    s = 7'b1000000;
            4'h1:    s = 7'b1111001;
            4'h2:    s = 7'b0100100;
            4'h3:    s = 7'b0110000;
            4'h4:    s = 7'b0011001;
            4'h5:    s = 7'b0010010;
            4'h6:    s = 7'b0000010;
            4'h7:    s = 7'b1111000;
            4'h8:    s = 7'b0000000;
            4'h9:    s = 7'b0010000;
            4'hA:    s = 7'b0001000;
            4'hB:    s = 7'b0000011;
            4'hC:    s = 7'b1000110;
            4'hD:    s = 7'b0100001;
            4'hE:    s = 7'b0000110;
            default: s = 7'b0001110;
        endcase
        return s;
    endfunction

    always_comb begin
        nib   = bus.sel ? bus.b_val[{idx_q, 2'b00} +: 4]
                        : bus.a_val[{idx_q, 2'b00} +: 4];
        blank = bus.blink_en & phase_q & bus.blink[idx_q];

        scan_cnt_d = scan_cnt_q + SCAN_ONE;
        idx_d      = idx_q;
        if (scan_cnt_q == SCAN_LAST) begin
            scan_cnt_d = '0;
            idx_d      = idx_q + 3'd1;
        end

        // Blink timebase free-runs so the cursor phase is stable across enables
        blink_cnt_d = blink_cnt_q + BLINK_ONE;
        phase_d     = phase_q;
        if (blink_cnt_q == BLINK_LAST) begin
            blink_cnt_d = '0;
            phase_d     = ~phase_q;
        end

        if (blank) begin
            an_d  = AN_OFF;
            seg_d = SEG_OFF;
            dp_d  = 1'b1;
        end else begin
            an_d  = ~(8'h01 << idx_q);
            seg_d = hex7(nib);
            dp_d  = ~bus.dp_mask[idx_q];
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            scan_cnt_q  <= '0;
            idx_q       <= '0;
            blink_cnt_q <= '0;
            phase_q     <= 1'b0;
            an_q        <= AN_OFF;
            seg_q       <= SEG_OFF;
            dp_q        <= 1'b1;
        end else begin
            scan_cnt_q  <= scan_cnt_d;
            idx_q       <= idx_d;
            blink_cnt_q <= blink_cnt_d;
            phase_q     <= phase_d;
            an_q        <= an_d;
            seg_q       <= seg_d;
            dp_q        <= dp_d;
        end
    end

    assign bus.an  = an_q;
    assign bus.seg = seg_q;
    assign bus.dp  = dp_q;

endmodule
`default_nettype wire

// File: tb/tb_seg_blink_scan.sv
`default_nettype none
// ============================================================================
// Module   : tb_seg_blink_scan
// Brief    : Two parameterisations of seg_blink_scan against a timing model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_seg_blink_scan;

    localparam int S_A = 4;
    localparam int B_A = 64;
    localparam int S_B = 1;
    localparam int B_B = 8;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [31:0] a_v = '0;
    logic [31:0] b_v = '0;
    logic        sel_v = 1'b0;
    logic [7:0]  blink_v = '0;
    logic        blink_en_v = 1'b0;
    logic [7:0]  dp_mask_v = '0;

    int total = 0;
    int bad   = 0;
    int e_a   = 0;   // edges since reset release, instance A
    int e_b   = 0;
    int cyc   = 0;

    always #5 clk = ~clk;

    seg_blink_scan_if if_a ();
    seg_blink_scan_if if_b ();

    assign if_a.a_val = a_v;       assign if_b.a_val = a_v;
    assign if_a.b_val = b_v;       assign if_b.b_val = b_v;
    assign if_a.sel = sel_v;       assign if_b.sel = sel_v;
    assign if_a.blink = blink_v;   assign if_b.blink = blink_v;
    assign if_a.blink_en = blink_en_v; assign if_b.blink_en = blink_en_v;
    assign if_a.dp_mask = dp_mask_v;   assign if_b.dp_mask = dp_mask_v;

    seg_blink_scan #(.SCAN_DIV(S_A), .BLINK_DIV(B_A)) u_dut_a (
        .clk (clk), .rst (rst), .bus (if_a.slave)
    );
    seg_blink_scan #(.SCAN_DIV(S_B), .BLINK_DIV(B_B)) u_dut_b (
        .clk (clk), .rst (rst), .bus (if_b.slave)
    );

    task automatic chk(input string tag, input logic [15:0] got, input logic [15:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s cyc=%0d got=%h exp=%h", tag, cyc, got, exp);
        end
    endtask

    function automatic logic [6:0] hex_ref(input int v);
        logic [6:0] t [16] = '{7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000,
                               7'b0011001, 7'b0010010, 7'b0000010, 7'b1111000,
                               7'b0000000, 7'b0010000, 7'b0001000, 7'b0000011,
                               7'b1000110, 7'b0100001, 7'b0000110, 7'b0001110};
        return t[v];
    endfunction

    // Expected {an,seg,dp} on edge e (1 = first edge after reset release)
    function automatic logic [15:0] model(input int s, input int b, input int e);
        int          d;
        int          ph;
        int          nv;
        logic [7:0]  an;
        d  = ((e - 1) / s) % 8;
        ph = ((e - 1) / b) % 2;
        nv = int'(((sel_v ? b_v : a_v) >> (4 * d)) & 32'hF);
        if (blink_en_v && ph == 1 && blink_v[d])
            return {8'hFF, 7'h7F, 1'b1};
        an    = 8'hFF;
        an[d] = 1'b0;
        return {an, hex_ref(nv), ~dp_mask_v[d]};
    endfunction

    task automatic tick();
        logic [15:0] exp_a;
        logic [15:0] exp_b;
        @(posedge clk);
        #1;
        cyc++;
        if (rst) begin
            e_a = 0; e_b = 0;
            exp_a = {8'hFF, 7'h7F, 1'b1};
            exp_b = exp_a;
        end else begin
            e_a++; e_b++;
            exp_a = model(S_A, B_A, e_a);
            exp_b = model(S_B, B_B, e_b);
        end
        chk(rst ? "rst_a" : "scan_a", {if_a.an, if_a.seg, if_a.dp}, exp_a);
        chk(rst ? "rst_b" : "scan_b", {if_b.an, if_b.seg, if_b.dp}, exp_b);
    endtask

    function automatic logic [7:0] rand_blink();
        case ($urandom_range(3))
            0:       return 8'h00;
            1:       return 8'h01 << $urandom_range(7);
            2:       return 8'hFF;
            default: return 8'($urandom);
        endcase
    endfunction

    initial begin
        // reset state and plain scan of 87654321
        a_v = 32'h87654321; b_v = 32'h12345678;
        repeat (2) tick();
        rst = 1'b0;
        repeat (40) tick();
        // live select change
        sel_v = 1'b1;
        repeat (3) tick();
        sel_v = 1'b0;
        // blinking cursor on digit 2, then same with blink disabled
        rst = 1'b1; tick(); rst = 1'b0;
        a_v = 32'hFFFFFFFF; blink_v = 8'h04; blink_en_v = 1'b1;
        repeat (70) tick();
        blink_en_v = 1'b0;
        repeat (40) tick();
        // whole display dark in blink phase
        blink_v = 8'hFF; blink_en_v = 1'b1;
        repeat (140) tick();
        // decimal points on the end digits
        blink_en_v = 1'b0; dp_mask_v = 8'h81; a_v = 32'h0123ABCD;
        repeat (36) tick();
        // reset while digit 5 of instance A is lit, mid-dwell
        rst = 1'b1; tick(); rst = 1'b0;
        repeat (22) tick();
        rst = 1'b1; tick(); rst = 1'b0;
        repeat (40) tick();
        // randomized traffic with occasional resets
        for (int i = 0; i < 3000; i++) begin
            if ($urandom_range(7) == 0) a_v = $urandom;
            if ($urandom_range(7) == 0) b_v = $urandom;
            if ($urandom_range(9) == 0) sel_v = 1'($urandom);
            if ($urandom_range(15) == 0) blink_v = rand_blink();
            if ($urandom_range(31) == 0) blink_en_v = 1'($urandom);
            if ($urandom_range(9) == 0) dp_mask_v = 8'($urandom);
            rst = ($urandom_range(399) == 0);
            tick();
        end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/seg_blink_scan.md
Name: seg_blink_scan

Overview:
- Downstream consumer of the operand-entry stage.
- Takes the two 32-bit operands it produces (Ai, Bi) and its one-hot digit cursor (blink).
- Drives the Nexys4 8-digit common-anode 7-segment display: time-multiplexed scan, hex decode, and blinking of the cursor digit so the operator can see which nibble BTNU/BTND will edit.

Parameters:
- SCAN_DIV, 100000, clock cycles each digit stays lit (1 kHz per digit at 100 MHz); legal range >= 1.
- BLINK_DIV, 25000000, clock cycles per blink half-period (2 Hz toggle at 100 MHz); legal range >= 1.

Ports:
- clk  in  1  system clock, all logic on rising edge
- rst  in  1  synchronous, active-high reset
- a_val  in  32  operand A; nibble i shown on digit i
- b_val  in  32  operand B
- sel  in  1  0 = display a_val, 1 = display b_val
- blink  in  8  digit cursor mask; bit i set = digit i blinks (one-hot in normal use, any pattern legal)
- blink_en  in  1  1 = blinking active, 0 = cursor ignored
- dp_mask  in  8  bit i set = decimal point of digit i lit
- an  out  8  digit anodes, active low
- seg  out  7  segments {g,f,e,d,c,b,a}, active low
- dp  out  1  decimal point, active low

Behaviour:
Interface:
- One clock, clk.
- Reset rst is synchronous and active-high.
- All outputs are registered.

Reset:
- Edge with rst=1 sets scan_cnt=0, idx=0, blink_cnt=0, phase=0, an=8'hFF, seg=7'h7F, dp=1.
- Reset asserted mid-scan returns every register to these values on that edge, regardless of counter state.

Scan counter:
- Counts 0..SCAN_DIV-1.
- At SCAN_DIV-1: wraps to 0 and idx (3 bits) increments mod 8; digit 7 is followed by digit 0.
- SCAN_DIV=1: idx advances every cycle.

Blink counter:
- Counts 0..BLINK_DIV-1.
- At BLINK_DIV-1: wraps to 0 and phase toggles.
- Runs continuously, independent of blink_en.

Output register, each edge with rst=0, computed from current (pre-update) idx and phase:
- nib = sel ? b_val[4*idx+:4] : a_val[4*idx+:4]
- blank = blink_en & phase & blink[idx]
- blank=1: an=8'hFF, seg=7'h7F, dp=1.
- blank=0: an=~(8'h01<<idx), seg=hex(nib), dp=~dp_mask[idx].
- Latency: one cycle from idx/phase/input change to pins.
- Inputs are sampled live every cycle. A change in a_val/b_val/sel/blink/dp_mask shows on the next edge; no hold-off until the digit boundary.

Digit timing after reset release:
- First rst=0 edge: digit 0 appears.
- Digit k occupies edges k*SCAN_DIV+1 .. (k+1)*SCAN_DIV (counting the first rst=0 edge as edge 1).
- Exactly one anode is low at any time when not blanked; never two.

Hex table (seg, active low, {g..a}):
- 0=1000000, 1=1111001, 2=0100100, 3=0110000
- 4=0011001, 5=0010010, 6=0000010, 7=1111000
- 8=0000000, 9=0010000, A=0001000, b=0000011
- C=1000110, d=0100001, E=0000110, F=0001110

Boundary cases:
- blink=0 or blink_en=0: no digit is ever blanked.
- blink=8'hFF with phase=1: whole display dark for the full half-period.
- Counter widths are $clog2-sized with no overflow for any legal parameter.

Test Plan:
1. SCAN_DIV=4, BLINK_DIV=64, rst pulse, a_val=32'h87654321, sel=0, blink_en=0 -> digit 0 first: an=8'hFE, seg=7'b1111001 for 4 cycles; then an=8'hFD, seg=0100100; full 0..7 sequence with seg for 1..8; wraps to an=8'hFE at cycle 33.
2. Same config, sel toggled to 1 with b_val=32'h12345678 -> the digit 0 currently lit shows seg=0000000 ('8') on the very next edge, with an unchanged.
3. SCAN_DIV=1, BLINK_DIV=8, blink=8'h04, blink_en=1, a_val=32'hFFFFFFFF -> for 8 cycles all digits are lit in turn (phase=0); for the next 8 cycles the digit-2 slot shows an=8'hFF, seg=7'h7F while the other digits show seg=0001110.
4. Repeat 3 with blink_en=0 -> digit 2 is never blanked; no cycle has an=8'hFF.
5. dp_mask=8'h81, scan all digits -> dp=0 only while an=8'h7F or 8'hFE; dp=1 otherwise.
6. Assert rst for one cycle while digit 5 is lit, mid-count -> next edge gives an=8'hFF, seg=7'h7F, dp=1; the following edge restarts at digit 0 with a full SCAN_DIV dwell and phase=0.
